vip_median_filter_3x3: RTL and testbench



---
 rtl/vip_median_filter_3x3_if.sv | 34 +++
 rtl/vip_median_filter_3x3.sv | 193 +++++++++++++++++++
 tb/tb_vip_median_filter_3x3.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vip_median_filter_3x3_if.sv
// Window-in / filtered-pixel-out bundle for the 3x3 median filter.
//   matrix_*  : frame syncs plus nine-pixel window from the matrix generator
//               (row 1 oldest line, column 3 newest pixel)
//   post_*    : syncs delayed 3 clk plus the filtered luma sample
// slave  : the filter side (consumes matrix_*, produces post_*)
// master : the upstream/downstream side driving the window and reading results
interface vip_median_filter_3x3_if;
    logic       matrix_frame_vsync;
    logic       matrix_frame_href;
    logic       matrix_frame_clken;
    logic [7:0] matrix_p11, matrix_p12, matrix_p13;
    logic [7:0] matrix_p21, matrix_p22, matrix_p23;
    logic [7:0] matrix_p31, matrix_p32, matrix_p33;
    logic       post_frame_vsync;
    logic       post_frame_href;
    logic       post_frame_clken;
    logic [7:0] post_img_Y;

    modport slave (
        input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        input  matrix_p11, matrix_p12, matrix_p13,
        input  matrix_p21, matrix_p22, matrix_p23,
        input  matrix_p31, matrix_p32, matrix_p33,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y
    );

    modport master (
        output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
        output matrix_p11, matrix_p12, matrix_p13,
        output matrix_p21, matrix_p22, matrix_p23,
        output matrix_p31, matrix_p32, matrix_p33,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Y
    );
endinterface

// File: rtl/vip_median_filter_3x3.sv
// Three-stage pipelined 3x3 median filter for 8-bit grey video.
//   clk : pixel clock
//   rst : synchronous active-high reset (pipeline, counters, syncs -> 0)
//   bus : vip_median_filter_3x3_if.slave
//         in  matrix_frame_vsync/href/clken, matrix_p11..matrix_p33
//         out post_frame_vsync/href/clken (inputs delayed 3 clk), post_img_Y
// Stage 1 sorts each window row, stage 2 reduces to max-of-mins /
// mid-of-mids / min-of-maxes, stage 3 takes their median. Windows that reach
// outside the image (first two lines / first two pixels of a line) are
// replaced by p22 or 0 depending on BORDER_MODE.
module vip_median_filter_3x3 #(
    parameter logic [9:0] IMG_HDISP   = 10'd640,
    parameter logic [9:0] IMG_VDISP   = 10'd480,
    parameter logic       BORDER_MODE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    vip_median_filter_3x3_if.slave        bus
);
    localparam int STAGES = 3;
    localparam int ROWS   = 3;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

    typedef struct packed {
        logic [7:0] max;
        logic [7:0] mid;
        logic [7:0] min;
    } sort3_t;

    // Full three-way sort with exactly three comparators.
    function automatic sort3_t sort3(input logic [7:0] a, b, c);
        sort3_t s;
        logic   ab, bc, ac;
        ab = (a >= b);
        bc = (b >= c);
        ac = (a >= c);
        if (ab && ac) begin
            s.max = a;
            s.mid = bc ? b : c;
            s.min = bc ? c : b;
        end else if (!ab && bc) begin
            s.max = b;
            s.mid = ac ? a : c;
            s.min = ac ? c : a;
        end else begin
            s.max = c;
            s.mid = ab ? a : b;
            s.min = ab ? b : a;
        end
        return s;
    endfunction

    function automatic logic [7:0] max3(input logic [7:0] a, b, c);
        logic [7:0] m;
        m = (a >= b) ? a : b;
        return (m >= c) ? m : c;
    endfunction

    function automatic logic [7:0] min3(input logic [7:0] a, b, c);
        logic [7:0] m;
        m = (a <= b) ? a : b;
        return (m <= c) ? m : c;
    endfunction

    function automatic logic [7:0] mid3(input logic [7:0] a, b, c);
        logic [7:0] lo, hi, hc;
        lo = (a <= b) ? a : b;
        hi = (a <= b) ? b : a;
        hc = (hi <= c) ? hi : c;
        return (lo >= hc) ? lo : hc;
    endfunction

    // ---------------- position counters ----------------
    logic       vsync_d, href_d;
    logic [9:0] col_cnt, row_cnt;
    logic       vsync_rise, href_fall, border_in;

    assign vsync_rise = bus.matrix_frame_vsync && !vsync_d;
    assign href_fall  = !bus.matrix_frame_href && href_d;
    // Pre-update counter values: the window being sampled this clk.
    assign border_in  = (col_cnt < 10'd2) || (row_cnt < 10'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            vsync_d <= bus.matrix_frame_vsync;
            href_d  <= bus.matrix_frame_href;
            if (!bus.matrix_frame_href)
                col_cnt <= '0;
            else if (bus.matrix_frame_clken && col_cnt < IMG_HDISP - 10'd1)
                col_cnt <= col_cnt + 10'd1;
            // Frame start takes priority over a coincident end of line.
            if (vsync_rise)
                row_cnt <= '0;
            else if (href_fall && row_cnt < IMG_VDISP - 10'd1)
                row_cnt <= row_cnt + 10'd1;
        end
    end

    // ---------------- sync delay line ----------------
    sync_t              sync_in;
    sync_t [STAGES:1]   sync_pipe;

    assign sync_in = '{vsync: bus.matrix_frame_vsync,
                       href:  bus.matrix_frame_href,
                       clken: bus.matrix_frame_clken};

    always_ff @(posedge clk) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[STAGES-1:1], sync_in};
    end

    // ---------------- stage 1: per-row sort ----------------
    logic   [ROWS-1:0][2:0][7:0] win;
    sort3_t [ROWS-1:0]           row_sort;

    assign win[0] = {bus.matrix_p11, bus.matrix_p12, bus.matrix_p13};
    assign win[1] = {bus.matrix_p21, bus.matrix_p22, bus.matrix_p23};
    assign win[2] = {bus.matrix_p31, bus.matrix_p32, bus.matrix_p33};

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign row_sort[r] = sort3(win[r][2], win[r][1], win[r][0]);
    end

    sort3_t [ROWS-1:0] s1_row;
    logic   [7:0]      s1_p22;
    logic              s1_border;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_row    <= '0;
            s1_p22    <= '0;
            s1_border <= 1'b0;
        end else begin
            s1_row    <= row_sort;
            s1_p22    <= bus.matrix_p22;
            s1_border <= border_in;
        end
    end

    // ---------------- stage 2: cross-row reduction ----------------
    logic [7:0] s2_max_of_mins, s2_mid_of_mids, s2_min_of_maxes, s2_p22;
    logic       s2_border;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_max_of_mins  <= '0;
            s2_mid_of_mids  <= '0;
            s2_min_of_maxes <= '0;
            s2_p22          <= '0;
            s2_border       <= 1'b0;
        end else begin
            s2_max_of_mins  <= max3(s1_row[0].min, s1_row[1].min, s1_row[2].min);
            s2_mid_of_mids  <= mid3(s1_row[0].mid, s1_row[1].mid, s1_row[2].mid);
            s2_min_of_maxes <= min3(s1_row[0].max, s1_row[1].max, s1_row[2].max);
            s2_p22          <= s1_p22;
            s2_border       <= s1_border;
        end
    end

    // ---------------- stage 3: median + border mux ----------------
    logic [7:0] s3_y;
    logic [7:0] border_val;

    assign border_val = BORDER_MODE ? s2_p22 : 8'd0;

    // sync_pipe[STAGES-1] is the href that lands in the output stage with
    // this result, so blanking uses it rather than the registered copy.
    always_ff @(posedge clk) begin
        if (rst)
            s3_y <= '0;
        else if (!sync_pipe[STAGES-1].href)
            s3_y <= '0;
        else if (s2_border)
            s3_y <= border_val;
        else
            s3_y <= mid3(s2_max_of_mins, s2_mid_of_mids, s2_min_of_maxes);
    end

    assign bus.post_frame_vsync = sync_pipe[STAGES].vsync;
    assign bus.post_frame_href  = sync_pipe[STAGES].href;
    assign bus.post_frame_clken = sync_pipe[STAGES].clken;
    assign bus.post_img_Y       = s3_y;
endmodule

// File: tb/tb_vip_median_filter_3x3.sv
// Self-checking bench for vip_median_filter_3x3: two instances (border mode 1
// and 0) share one stimulus stream; a sort-based reference with its own
// line/pixel bookkeeping predicts every output 3 clk after input.
module tb_vip_median_filter_3x3;
    localparam int H = 640;
    localparam int V = 480;

    typedef struct packed {
        logic            rst, vs, hr, ck;
        logic [8:0][7:0] win;   // [0]=p11 .. [4]=p22 .. [8]=p33
        int              kexp;  // fixed expected Y for border-mode-1, -1 none
    } stim_t;

    typedef struct packed {
        logic       vs, hr, ck;
        logic [7:0] y1, y0;
        int         kexp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vip_median_filter_3x3_if bus1 ();
    vip_median_filter_3x3_if bus0 ();

    vip_median_filter_3x3 #(.BORDER_MODE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    vip_median_filter_3x3 #(.BORDER_MODE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.matrix_frame_vsync = bus1.matrix_frame_vsync;
    assign bus0.matrix_frame_href  = bus1.matrix_frame_href;
    assign bus0.matrix_frame_clken = bus1.matrix_frame_clken;
    assign bus0.matrix_p11 = bus1.matrix_p11;
    assign bus0.matrix_p12 = bus1.matrix_p12;
    assign bus0.matrix_p13 = bus1.matrix_p13;
    assign bus0.matrix_p21 = bus1.matrix_p21;
    assign bus0.matrix_p22 = bus1.matrix_p22;
    assign bus0.matrix_p23 = bus1.matrix_p23;
    assign bus0.matrix_p31 = bus1.matrix_p31;
    assign bus0.matrix_p32 = bus1.matrix_p32;
    assign bus0.matrix_p33 = bus1.matrix_p33;

    int    checks = 0;
    int    errors = 0;
    stim_t stim_q[$];

    // reference state
    int   m_col, m_row;
    bit   m_pvs, m_phr;
    exp_t dl[3];
    exp_t now;
    exp_t zero_e;

    function automatic logic [7:0] ref_median(input logic [8:0][7:0] w);
        int v[9];
        int t;
        for (int i = 0; i < 9; i++) v[i] = int'(w[i]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        return 8'(v[4]);
    endfunction

    function automatic logic [8:0][7:0] rand_win(input int mode);
        logic [8:0][7:0] w;
        for (int i = 0; i < 9; i++)
            w[i] = (mode == 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        if (mode == 1) begin
            w = '0;
            w[4] = 8'hA5;
        end
        return w;
    endfunction

    function automatic stim_t mk(input bit r, vs, hr, ck, input logic [8:0][7:0] w, input int k);
        stim_t s;
        s.rst = r; s.vs = vs; s.hr = hr; s.ck = ck; s.win = w; s.kexp = k;
        return s;
    endfunction

    function automatic logic [21:0] obs();
        return {bus1.post_frame_vsync, bus1.post_frame_href, bus1.post_frame_clken,
                bus1.post_img_Y, bus0.post_img_Y,
                bus0.post_frame_vsync, bus0.post_frame_href, bus0.post_frame_clken};
    endfunction

    function automatic logic [21:0] expv(input exp_t e);
        return {e.vs, e.hr, e.ck, e.y1, e.y0, e.vs, e.hr, e.ck};
    endfunction

    task automatic add_idle(input int n, input bit vs);
        for (int i = 0; i < n; i++) stim_q.push_back(mk(0, vs, 0, 0, rand_win(0), -1));
    endtask

    // krow >= 0 with mode 1 attaches the known border/interior value per pixel
    task automatic add_line(input int px, input bit gap, input int mode, input int krow,
                            input bit vs, input bit vs_tail);
        int k;
        for (int p = 0; p < px; p++) begin
            k = -1;
            if (mode == 1 && krow >= 0) k = (krow < 2 || p < 2) ? 'hA5 : 0;
            stim_q.push_back(mk(0, vs, 1, 1, rand_win(mode), k));
            if (gap) stim_q.push_back(mk(0, vs, 1, 0, rand_win(0), -1));
        end
        add_idle(2, vs_tail);
    endtask

    task automatic add_frame(input int w, input int h, input bit gap, input int mode);
        add_idle(2, 0);
        add_idle(2, 1);
        for (int l = 0; l < h; l++) add_line(w, gap, mode, l, 1, 1);
        add_idle(2, 0);
    endtask

    // One clock: outputs now reflect the inputs of three calls ago.
    task automatic cyc(input stim_t s);
        exp_t e;
        bit   border;
        logic [7:0] med;
        @(negedge clk);
        now   = dl[2];
        dl[2] = dl[1];
        dl[1] = dl[0];
        rst = s.rst;
        bus1.matrix_frame_vsync = s.vs;
        bus1.matrix_frame_href  = s.hr;
        bus1.matrix_frame_clken = s.ck;
        bus1.matrix_p11 = s.win[0]; bus1.matrix_p12 = s.win[1]; bus1.matrix_p13 = s.win[2];
        bus1.matrix_p21 = s.win[3]; bus1.matrix_p22 = s.win[4]; bus1.matrix_p23 = s.win[5];
        bus1.matrix_p31 = s.win[6]; bus1.matrix_p32 = s.win[7]; bus1.matrix_p33 = s.win[8];
        if (s.rst) begin
            m_col = 0; m_row = 0; m_pvs = 0; m_phr = 0;
            dl[1] = zero_e; dl[2] = zero_e;
            e = zero_e;
        end else begin
            border = (m_col < 2) || (m_row < 2);
            med    = ref_median(s.win);
            e.vs = s.vs; e.hr = s.hr; e.ck = s.ck; e.kexp = s.kexp;
            e.y1 = !s.hr ? 8'd0 : border ? s.win[4] : med;
            e.y0 = !s.hr ? 8'd0 : border ? 8'd0     : med;
            if (s.vs && !m_pvs) m_row = 0;
            else if (!s.hr && m_phr && m_row < V - 1) m_row++;
            if (!s.hr) m_col = 0;
            else if (s.ck && m_col < H - 1) m_col++;
            m_pvs = s.vs; m_phr = s.hr;
        end
        dl[0] = e;
    endtask

    task automatic test_reset();
        stim_t s;
        int idx = 0, first_in = -1, first_out = -1;
        for (int i = 0; i < 4; i++) begin
            s = mk(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), rand_win(0), -1);
            cyc(s);
            if (i > 0) begin
                checks++;
                if (obs() !== 22'd0) begin
                    errors++;
                    $display("FAIL reset_outputs: got %h want 0", obs());
                end
            end
        end
        add_frame(8, 4, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            if (s.ck && first_in < 0) first_in = idx;
            cyc(s);
            checks++;
            if (obs() !== expv(now)) begin
                errors++;
                $display("FAIL reset_frame: got %h want %h", obs(), expv(now));
            end
            if (bus1.post_frame_clken && first_out < 0) first_out = idx;
            idx++;
        end
        checks++;
        if (first_out - first_in !== 3) begin
            errors++;
            $display("FAIL first_latency: got %0d want 3", first_out - first_in);
        end
    endtask

    task automatic test_median();
        stim_t s;
        int base;
        logic [8:0][7:0] fw[4];
        int kv[4] = '{50, 0, 7, 5};
        fw[0] = {8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
        fw[1] = {8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255};
        fw[2] = {9{8'd7}};
        fw[3] = {8'd5, 8'd4, 8'd6, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9};
        add_idle(2, 0);
        add_idle(1, 1);
        base = 0;
        for (int l = 0; l < 6; l++) begin
            if (l == 5) base = stim_q.size();
            add_line(14, 0, 0, -1, 1, 1);
        end
        add_idle(2, 0);
        for (int i = 0; i < 4; i++) begin
            s = stim_q[base + 10 + i];
            s.win  = fw[i];
            s.kexp = kv[i];
            stim_q[base + 10 + i] = s;
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cyc(s);
            checks++;
            if (obs() !== expv(now)) begin
                errors++;
                $display("FAIL median: got %h want %h", obs(), expv(now));
            end
            if (now.kexp >= 0) begin
                checks++;
                if (bus1.post_img_Y !== 8'(now.kexp)) begin
                    errors++;
                    $display("FAIL median_const: got %0d want %0d", bus1.post_img_Y, now.kexp);
                end
            end
        end
    endtask

    // Also used for column saturation: a 1030-pixel line would wrap an
    // unsaturated 10-bit counter back into the border region.
    task automatic test_border(input int w, input int h, input int frames, input string tag);
        stim_t s;
        for (int f = 0; f < frames; f++) add_frame(w, h, 0, 1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cyc(s);
            checks++;
            if (obs() !== expv(now)) begin
                errors++;
                $display("FAIL %s: got %h want %h", tag, obs(), expv(now));
            end
            if (now.kexp >= 0) begin
                checks++;
                if (bus1.post_img_Y !== 8'(now.kexp)) begin
                    errors++;
                    $display("FAIL %s_const: got %h want %h", tag, bus1.post_img_Y, 8'(now.kexp));
                end
            end
        end
    endtask

    task automatic test_sync_gapped();
        stim_t s;
        int pulses = 0;
        add_frame(64, 10, 1, 2);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cyc(s);
            checks++;
            if (obs() !== expv(now)) begin
                errors++;
                $display("FAIL sync_gapped: got %h want %h", obs(), expv(now));
            end
            if (bus1.post_frame_clken) pulses++;
        end
        checks++;
        if (pulses !== 64 * 10) begin
            errors++;
            $display("FAIL clken_count: got %0d want %0d", pulses, 64 * 10);
        end
    endtask

    task automatic test_vs_href_coincide();
        stim_t s;
        add_idle(2, 0);
        add_line(6, 0, 1, -1, 0, 1);   // href falls on the same clk vsync rises
        for (int l = 0; l < 4; l++) add_line(6, 0, 1, l, 1, 1);
        add_idle(2, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cyc(s);
            checks++;
            if (obs() !== expv(now)) begin
                errors++;
                $display("FAIL coincide: got %h want %h", obs(), expv(now));
            end
            if (now.kexp >= 0) begin
                checks++;
                if (bus1.post_img_Y !== 8'(now.kexp)) begin
                    errors++;
                    $display("FAIL coincide_const: got %h want %h", bus1.post_img_Y, 8'(now.kexp));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        stim_t s;
        bit after_rst = 0;
        add_idle(2, 0);
        add_idle(1, 1);
        for (int l = 0; l < 100; l++) add_line(4, 0, 0, -1, 1, 1);
        stim_q.push_back(mk(0, 1, 1, 1, rand_win(0), -1));
        stim_q.push_back(mk(0, 1, 1, 1, rand_win(0), -1));
        stim_q.push_back(mk(1, 1, 1, 1, rand_win(0), -1));
        for (int p = 0; p < 3; p++) stim_q.push_back(mk(0, 1, 1, 1, rand_win(1), 'hA5));
        add_idle(2, 1);
        for (int l = 1; l < 4; l++) add_line(6, 0, 1, l, 1, 1);
        add_idle(2, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            cyc(s);
            checks++;
            if (obs() !== expv(now)) begin
                errors++;
                $display("FAIL mid_reset: got %h want %h", obs(), expv(now));
            end
            if (after_rst) begin
                checks++;
                if (obs() !== 22'd0) begin
                    errors++;
                    $display("FAIL mid_reset_zero: got %h want 0", obs());
                end
            end
            if (now.kexp >= 0) begin
                checks++;
                if (bus1.post_img_Y !== 8'(now.kexp)) begin
                    errors++;
                    $display("FAIL mid_reset_const: got %h want %h", bus1.post_img_Y, 8'(now.kexp));
                end
            end
            after_rst = s.rst;
        end
    endtask

    initial begin
        zero_e = '0;
        zero_e.kexp = -1;
        for (int i = 0; i < 3; i++) dl[i] = zero_e;
        m_col = 0; m_row = 0; m_pvs = 0; m_phr = 0;
        rst = 1'b1;
        test_reset();
        test_median();
        test_border(16, 6, 2, "border");
        test_sync_gapped();
        test_border(1030, 3, 1, "col_saturate");
        test_vs_href_coincide();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
